// File: rtl/mic_fifo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mic_fifo_pkg                                                          |
// | Shared defaults, clog2 helper and sample type for the mic sample path |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mic_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int c_default_data_w    = 16;
  localparam int c_default_depth     = 128;
  localparam int c_default_addr_w    = clog2(c_default_depth);
  localparam int c_default_af_thresh = 120;
  localparam int c_default_ae_thresh = 8;
  localparam int c_default_frame_len = 64;

  typedef logic [c_default_data_w-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/mic_fifo_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mic_fifo_ram                                                          |
// | Simple dual-port RAM: one write port, one registered read port        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mic_fifo_ram
  import mic_fifo_pkg::*;
#(
  parameter int DATA_W = c_default_data_w,
  parameter int ADDR_W = c_default_addr_w
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read-before-write: a same-address read returns the old entry.
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mic_sample_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mic_sample_fifo                                                       |
// | Synchronous sample FIFO with occupancy, status and sticky error flags |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mic_sample_fifo
  import mic_fifo_pkg::*;
#(
  parameter int DATA_W    = c_default_data_w,
  parameter int ADDR_W    = c_default_addr_w,
  parameter int AF_THRESH = c_default_af_thresh,
  parameter int AE_THRESH = c_default_ae_thresh,
  parameter int FRAME_LEN = c_default_frame_len
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              frame_avail,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int c_depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_af_thresh = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] c_ae_thresh = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] c_frame_len = FRAME_LEN[ADDR_W:0];

  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= c_depth) && (FRAME_LEN <= c_depth)))
  begin : g_param_check
    $error("mic_sample_fifo: need AE_THRESH < AF_THRESH <= DEPTH and FRAME_LEN <= DEPTH");
  end

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_dout_valid;
  logic              r_dout_loaded;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_ram_q;

  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  // Flush and reset drop the cycle's ops, so the RAM never sees them.
  assign w_ram_we = w_wr_acc & ~flush & rst;
  assign w_ram_re = w_rd_acc & ~flush & rst;

  mic_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .re    (w_ram_re),
    .raddr (r_rd_ptr[ADDR_W-1:0]),
    .rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_dout_valid  <= 1'b0;
      r_dout_loaded <= 1'b0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr      <= r_rd_ptr + 1'b1;
        r_dout_loaded <= 1'b1;
      end
      r_count      <= r_count + {{ADDR_W{1'b0}}, w_wr_acc} - {{ADDR_W{1'b0}}, w_rd_acc};
      r_dout_valid <= w_rd_acc;
    end
  end

  // A new error in the same cycle outranks err_clr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!flush) begin
      if (wr_en & ~w_wr_acc) r_overflow <= 1'b1;
      else if (err_clr)      r_overflow <= 1'b0;
      if (rd_en & ~w_rd_acc) r_underflow <= 1'b1;
      else if (err_clr)      r_underflow <= 1'b0;
    end
  end

  // The RAM read register has no reset; mask it until the first read lands.
  assign dout         = r_dout_loaded ? w_ram_q : '0;
  assign dout_valid   = r_dout_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= c_af_thresh);
  assign almost_empty = (r_count <= c_ae_thresh);
  assign frame_avail  = (r_count >= c_frame_len);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_mic_sample_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mic_sample_fifo                                                    |
// | Directed, table-driven self-checking bench for mic_sample_fifo        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mic_sample_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [15:0] din;
  logic        rd_en;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        frame_avail;
  logic [7:0]  count;
  logic        overflow;
  logic        underflow;
  logic        err_clr;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        fl;
    logic        ec;
    logic [15:0] din;
    logic [7:0]  cnt;
    logic        valid;
    logic        chk_dout;
    logic [15:0] dout;
    logic        ov;
    logic        uf;
    logic        empty;
    logic        ae;
  } vec_t;

  vec_t vecs [0:7];

  mic_sample_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .frame_avail  (frame_avail),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    wr_en   = vecs[i].wr;
    rd_en   = vecs[i].rd;
    flush   = vecs[i].fl;
    err_clr = vecs[i].ec;
    din     = vecs[i].din;
    tick();
    chk($sformatf("v%0d count", i), count, vecs[i].cnt);
    chk($sformatf("v%0d dout_valid", i), dout_valid, vecs[i].valid);
    if (vecs[i].chk_dout) chk($sformatf("v%0d dout", i), dout, vecs[i].dout);
    chk($sformatf("v%0d overflow", i), overflow, vecs[i].ov);
    chk($sformatf("v%0d underflow", i), underflow, vecs[i].uf);
    chk($sformatf("v%0d empty", i), empty, vecs[i].empty);
    chk($sformatf("v%0d almost_empty", i), almost_empty, vecs[i].ae);
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //            wr rd fl ec din       cnt vld chk dout     ov uf emp ae
    // underflow / empty write, error-vs-clear priority
    vecs[0] = '{1, 1, 0, 0, 16'h1234, 1, 0, 1, 16'h0309, 0, 1, 0, 1};
    vecs[1] = '{0, 1, 0, 0, 16'h0000, 0, 1, 1, 16'h1234, 0, 1, 1, 1};
    vecs[2] = '{0, 0, 0, 1, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 1, 1};
    vecs[3] = '{0, 1, 0, 1, 16'h0000, 0, 0, 1, 16'h1234, 0, 1, 1, 1};
    vecs[4] = '{0, 0, 0, 1, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 1, 1};
    // flush at count 50 with both ops requested, then fresh data
    vecs[5] = '{1, 1, 1, 0, 16'hDEAD, 0, 0, 1, 16'h0400, 0, 0, 1, 1};
    vecs[6] = '{1, 0, 0, 0, 16'h5555, 1, 0, 1, 16'h0400, 0, 0, 0, 1};
    vecs[7] = '{0, 1, 0, 0, 16'h0000, 0, 1, 1, 16'h5555, 0, 0, 1, 1};

    // Reset held with a pending write
    rst = 0; flush = 0; wr_en = 1; rd_en = 0; err_clr = 0; din = 16'hAAAA;
    repeat (3) tick();
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst almost_empty", almost_empty, 1);
    chk("rst dout_valid", dout_valid, 0);
    chk("rst dout", dout, 0);
    chk("rst overflow", overflow, 0);
    chk("rst underflow", underflow, 0);
    rst = 1; wr_en = 0;
    tick();
    chk("post-rst count", count, 0);

    // Fill 0x0000..0x007F with threshold tracking
    for (int i = 0; i < 128; i++) begin
      wr_en = 1; din = 16'(i);
      tick();
      chk($sformatf("fill%0d count", i), count, i + 1);
      chk($sformatf("fill%0d frame_avail", i), frame_avail, (i + 1 >= 64));
      chk($sformatf("fill%0d almost_full", i), almost_full, (i + 1 >= 120));
      chk($sformatf("fill%0d full", i), full, (i + 1 == 128));
    end
    wr_en = 0;

    // Overflow at full, then clear
    wr_en = 1; din = 16'hBEEF;
    tick();
    wr_en = 0;
    chk("ovf count", count, 128);
    chk("ovf flag", overflow, 1);
    chk("ovf full", full, 1);
    tick();
    chk("ovf sticky", overflow, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("ovf cleared", overflow, 0);

    // Drain 128: data order, latency and almost_empty
    for (int j = 0; j < 128; j++) begin
      rd_en = 1;
      tick();
      chk($sformatf("drain%0d dout_valid", j), dout_valid, 1);
      chk($sformatf("drain%0d dout", j), dout, 16'(j));
      chk($sformatf("drain%0d almost_empty", j), almost_empty, (127 - j <= 8));
    end
    rd_en = 0;
    tick();
    chk("drain dout_valid low", dout_valid, 0);
    chk("drain empty", empty, 1);
    chk("drain underflow", underflow, 0);

    // Refill, then simultaneous read+write while full across the wrap
    for (int i = 0; i < 128; i++) begin
      wr_en = 1; din = 16'h0200 + 16'(i);
      tick();
    end
    chk("refill full", full, 1);
    for (int k = 0; k < 10; k++) begin
      wr_en = 1; rd_en = 1; din = 16'h0300 + 16'(k);
      tick();
      chk($sformatf("simul%0d count", k), count, 128);
      chk($sformatf("simul%0d full", k), full, 1);
      chk($sformatf("simul%0d overflow", k), overflow, 0);
      chk($sformatf("simul%0d dout", k), dout, 16'h0200 + 16'(k));
    end
    wr_en = 0;
    for (int j = 0; j < 128; j++) begin
      rd_en = 1;
      tick();
      chk($sformatf("wrap%0d dout", j), dout,
          (j < 118) ? 16'h0200 + 16'(j + 10) : 16'h0300 + 16'(j - 118));
    end
    rd_en = 0;
    tick();
    chk("wrap empty", empty, 1);
    chk("wrap underflow", underflow, 0);

    for (int i = 0; i < 5; i++) apply_vec(i);

    // Bring occupancy to 50 with a valid read in flight before the flush
    for (int i = 0; i < 51; i++) begin
      wr_en = 1; din = 16'h0400 + 16'(i);
      tick();
    end
    wr_en = 0; rd_en = 1;
    tick();
    rd_en = 0;
    chk("preflush count", count, 50);
    chk("preflush dout", dout, 16'h0400);

    for (int i = 5; i < 8; i++) apply_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
